// File: rtl/sr595_pkg.sv
// Shared types for the 74HC595 chain driver.
package sr595_pkg;

   typedef enum logic [1:0] {
      SR_IDLE  = 2'd0,
      SR_SHIFT = 2'd1,
      SR_LATCH = 2'd2
   } sr_state_t;

endpackage

// File: rtl/sr_clk_div.sv
// Phase divider: counts 0..CLK_DIV-1 and flags the terminal count; clear restarts from 0.
module sr_clk_div #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = $clog2(CLK_DIV + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == LAST);

   // Next count: restart on clear or terminal count, otherwise advance.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Divider count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sr595_chain_driver.sv
// Serial driver for a chain of 74HC595 shift registers: shifts a DATA_W word out on
// SER/SRCLK, pulses RCLK to latch it, then strobes done for one cycle.
module sr595_chain_driver
   import sr595_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int CLK_DIV   = 4,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   output logic              busy,
   output logic              done,
   output logic              SER,
   output logic              SRCLK,
   output logic              RCLK
);

   localparam int BIT_W = $clog2(DATA_W + 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

   sr_state_t         state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d, shifted_s;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              ser_q, ser_d;
   logic              srclk_q, srclk_d;
   logic              rclk_q, rclk_d;
   logic              done_q, done_d;
   logic              tick_s;
   logic              div_clear_s;

   function automatic logic first_bit(input logic [DATA_W-1:0] w);
      first_bit = LSB_FIRST ? w[0] : w[DATA_W-1];
   endfunction

   // Holding the divider cleared while idle makes every transfer start from a fresh phase.
   assign div_clear_s = (state_q == SR_IDLE);
   assign shifted_s   = LSB_FIRST ? (shreg_q >> 1'd1) : (shreg_q << 1'd1);

   sr_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (div_clear_s),
      .tick  (tick_s)
   );

   // Transfer sequencing: SRCLK doubles as the low/high phase flag within a bit.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      ser_d     = ser_q;
      srclk_d   = srclk_q;
      rclk_d    = rclk_q;
      done_d    = 1'b0;
      case (state_q)
         SR_IDLE: begin
            ser_d     = 1'b0;
            srclk_d   = 1'b0;
            rclk_d    = 1'b0;
            bit_cnt_d = '0;
            if (data_valid) begin
               shreg_d = data_in;
               ser_d   = first_bit(data_in);
               state_d = SR_SHIFT;
            end else begin
               shreg_d = shreg_q;
            end
         end
         SR_SHIFT: begin
            if (tick_s && !srclk_q) begin
               srclk_d = 1'b1;
            end else if (tick_s) begin
               srclk_d   = 1'b0;
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
               if (bit_cnt_q == LAST_BIT) begin
                  ser_d   = 1'b0;
                  rclk_d  = 1'b1;
                  state_d = SR_LATCH;
               end else begin
                  shreg_d = shifted_s;
                  ser_d   = first_bit(shifted_s);
               end
            end else begin
               srclk_d = srclk_q;
            end
         end
         SR_LATCH: begin
            if (tick_s) begin
               rclk_d  = 1'b0;
               done_d  = 1'b1;
               state_d = SR_IDLE;
            end else begin
               rclk_d = 1'b1;
            end
         end
         default: begin
            state_d = SR_IDLE;
            ser_d   = 1'b0;
            srclk_d = 1'b0;
            rclk_d  = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= SR_IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         ser_q     <= 1'b0;
         srclk_q   <= 1'b0;
         rclk_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         ser_q     <= ser_d;
         srclk_q   <= srclk_d;
         rclk_q    <= rclk_d;
         done_q    <= done_d;
      end
   end

   assign data_ready = (state_q == SR_IDLE);
   assign busy       = !data_ready;
   assign done       = done_q;
   assign SER        = ser_q;
   assign SRCLK      = srclk_q;
   assign RCLK       = rclk_q;

endmodule

// File: tb/tb_sr595_chain_driver.sv
// Bench for sr595_chain_driver: four configurations, each watched by a 595-chain model
// and a scoreboard monitor that checks latched word, latency and pulse counts on done.
module tb_sr595_chain_driver;

   typedef struct {
      logic [15:0] word;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] din [4];
   logic [3:0]  vld;
   logic [3:0]  rdy_w, bsy_w, dn_w, ser_w, sck_w, rck_w;
   exp_t        exp_q [4][$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int pending();
      int s = 0;
      for (int i = 0; i < 4; i++) s += exp_q[i].size();
      return s;
   endfunction

   // Configurations: 0 = 8/2/MSB, 1 = 8/2/LSB, 2 = 16/1/MSB, 3 = 1/1/MSB.
   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int DW = (g == 2) ? 16 : ((g == 3) ? 1 : 8);
      localparam int CD = (g < 2) ? 2 : 1;
      localparam bit LF = (g == 1);
      localparam logic [15:0] MASK = 16'((32'd1 << DW) - 32'd1);

      logic [15:0] chain, latched;
      int          rises, pulses, acc_cyc;
      logic        sck_prev, rck_prev;
      exp_t        e;

      sr595_chain_driver #(
         .DATA_W    (DW),
         .CLK_DIV   (CD),
         .LSB_FIRST (LF)
      ) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .data_in    (din[g][DW-1:0]),
         .data_valid (vld[g]),
         .data_ready (rdy_w[g]),
         .busy       (bsy_w[g]),
         .done       (dn_w[g]),
         .SER        (ser_w[g]),
         .SRCLK      (sck_w[g]),
         .RCLK       (rck_w[g])
      );

      initial begin
         chain = 16'h0; latched = 16'h0; rises = 0; pulses = 0; acc_cyc = 0;
         sck_prev = 1'b0; rck_prev = 1'b0;
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               sck_prev = 1'b0;
               rck_prev = 1'b0;
            end else begin
               if (sck_w[g] && !sck_prev) begin
                  rises++;
                  chain = {chain[14:0], ser_w[g]};
               end
               if (rck_w[g] && !rck_prev) begin
                  pulses++;
                  latched = chain;
               end
               sck_prev = sck_w[g];
               rck_prev = rck_w[g];
               check("busy_vs_ready", 32'(bsy_w[g]), 32'(!rdy_w[g]));
               if (rdy_w[g]) check("idle_pins", {29'd0, ser_w[g], sck_w[g], rck_w[g]}, 32'd0);
               if (dn_w[g]) begin
                  if (exp_q[g].size() == 0) begin
                     check("unexpected_done", 32'(dn_w[g]), 32'd0);
                  end else begin
                     e = exp_q[g].pop_front();
                     check("latched_word", 32'(latched & MASK), 32'(e.word));
                     check("latency", cyc - acc_cyc, e.lat);
                     check("srclk_rises", rises, DW);
                     check("rclk_pulses", pulses, 1);
                  end
               end
               if (rdy_w[g] && vld[g]) begin
                  acc_cyc = cyc + 1;
                  rises   = 0;
                  pulses  = 0;
                  chain   = 16'h0;
               end
            end
         end
      end
   end

   // Issue one word to an idle instance; called #1 after a rising edge.
   task automatic send(input int i, input logic [15:0] d, input logic [15:0] chain_exp,
                       input int lat, input bit expect_done);
      din[i] = d;
      vld[i] = 1'b1;
      if (expect_done) exp_q[i].push_back('{word: chain_exp, lat: lat});
      @(posedge clk); #1;
      vld[i] = 1'b0;
      din[i] = ~d;
      check("accepted", 32'(rdy_w[i]), 32'd0);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (pending() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      check("drain", pending(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      vld   = 4'b0000;
      for (int i = 0; i < 4; i++) din[i] = 16'h0000;
      #2;
      for (int i = 0; i < 4; i++) begin
         check("reset_pins", {28'd0, ser_w[i], sck_w[i], rck_w[i], dn_w[i]}, 32'd0);
         check("reset_ready", 32'(rdy_w[i]), 32'd1);
         check("reset_busy", 32'(bsy_w[i]), 32'd0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      send(0, 16'h000F, 16'h000F, 34, 1'b1);
      send(1, 16'h000F, 16'h00F0, 34, 1'b1);
      send(2, 16'h8001, 16'h8001, 33, 1'b1);
      send(3, 16'h0001, 16'h0001, 3, 1'b1);
      drain(300);

      send(1, 16'h00B1, 16'h008D, 34, 1'b1);
      send(2, 16'hA55A, 16'hA55A, 33, 1'b1);
      send(3, 16'h0000, 16'h0000, 3, 1'b1);
      drain(300);

      // Back-to-back: valid held, second word taken in the done cycle.
      din[0] = 16'h0012;
      vld[0] = 1'b1;
      exp_q[0].push_back('{word: 16'h0012, lat: 34});
      exp_q[0].push_back('{word: 16'h0034, lat: 34});
      @(posedge clk); #1;
      check("b2b_first_accept", 32'(rdy_w[0]), 32'd0);
      din[0] = 16'h0034;
      n = 0;
      while (!dn_w[0] && n < 100) begin
         check("b2b_ready_low", 32'(rdy_w[0]), 32'd0);
         @(posedge clk); #1;
         n++;
      end
      check("b2b_first_done", 32'(dn_w[0]), 32'd1);
      @(posedge clk); #1;
      check("b2b_second_accept", 32'(rdy_w[0]), 32'd0);
      vld[0] = 1'b0;
      din[0] = 16'h0000;
      drain(200);

      // Requests and data changes while busy must be ignored.
      send(0, 16'h00C3, 16'h00C3, 34, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      din[0] = 16'h00FF;
      vld[0] = 1'b1;
      @(posedge clk); #1;
      vld[0] = 1'b0;
      for (int k = 0; k < 6; k++) begin
         din[0] = ~din[0];
         @(posedge clk); #1;
      end
      drain(200);

      // Reset after three SRCLK rises aborts without latching.
      send(0, 16'h003C, 16'h0000, 0, 1'b0);
      n = 0;
      while (g_dut[0].rises < 3 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("abort_rises", g_dut[0].rises, 3);
      #1 rst_n = 1'b0;
      #1;
      check("abort_pins", {28'd0, ser_w[0], sck_w[0], rck_w[0], dn_w[0]}, 32'd0);
      check("abort_ready", 32'(rdy_w[0]), 32'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("abort_no_latch", g_dut[0].pulses, 0);
      check("abort_ready_after", 32'(rdy_w[0]), 32'd1);
      send(0, 16'h00A5, 16'h00A5, 34, 1'b1);
      drain(200);

      repeat (40) @(posedge clk);
      check("final_queue_empty", pending(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
